uart_tx_fifo: RTL and testbench

//  Byte buffer upstream of the UART transmitter: the processor MMIO side pushes bytes at bus speed.
//  The block drains them one frame at a time into the transmitter's Tx_Data/tx_send inputs.
//  The transmitter has no busy output, so this block paces frames itself with a frame-time counter.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo_param.sv | 88 ++++++++
 rtl/uart_tx_fifo.sv | 131 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame timing constants and the TX FIFO drain FSM state type.
package uart_pkg;

   localparam int BAUD_COUNTS_9600 = 5210;
   localparam int UART_FRAME_BITS  = 11;

   typedef enum logic [1:0] {
      TXF_IDLE = 2'd0,
      TXF_LOAD = 2'd1,
      TXF_SEND = 2'd2,
      TXF_WAIT = 2'd3
   } tx_fifo_state_t;

endpackage

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered occupancy count, decoded full/empty and a sticky overflow flag.
module sync_fifo_param #(
   parameter int width = 8,
   parameter int depth = 16
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    wr_en,
   input  logic [width-1:0]        wr_data,
   input  logic                    rd_en,
   input  logic                    clr_overflow,
   output logic [width-1:0]        rd_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(depth):0]  count,
   output logic                    overflow
);

   localparam int AW = $clog2(depth);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW-1:0] PTR_ZERO = AW'(0);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(depth);

   logic [width-1:0] mem_r [depth];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             overflow_r;
   logic             push_s;
   logic             pop_s;

   // Flags come from the count register only, so pushes see the pre-edge full state.
   assign full     = (count_r == CNT_FULL);
   assign empty    = (count_r == CNT_ZERO);
   assign count    = count_r;
   assign overflow = overflow_r;
   assign rd_data  = mem_r[rd_ptr_r];

   // Qualify push/pop against the current flags.
   always_comb begin
      push_s = wr_en && !full;
      pop_s  = rd_en && !empty;
   end

   // Storage array; contents are don't-care after reset because the pointers restart.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky overflow; a dropped write takes priority over a clear in the same cycle.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         overflow_r <= 1'b0;
      end else if (wr_en && full) begin
         overflow_r <= 1'b1;
      end else if (clr_overflow) begin
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= overflow_r;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer feeding the UART transmitter, pacing one frame at a time with a frame-time counter
// because the transmitter exposes no busy indication.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int FRAME_CYCLES = UART_FRAME_BITS * BAUD_COUNTS_9600,
   parameter int GAP_CYCLES   = 0
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    wr_en,
   input  logic [7:0]              wr_data,
   input  logic                    clr_overflow,
   output logic [7:0]              tx_data,
   output logic                    tx_send,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    busy,
   output logic                    overflow
);

   localparam int FRAME_TOTAL = FRAME_CYCLES + GAP_CYCLES;
   localparam int CW          = $clog2(FRAME_TOTAL + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_TOTAL - 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   tx_fifo_state_t state_r;
   tx_fifo_state_t state_nxt_s;
   logic [CW-1:0]  cnt_r;
   logic [7:0]     tx_data_r;
   logic           tx_send_r;
   logic           busy_r;
   logic           rd_en_s;
   logic [7:0]     rd_data_s;
   logic           empty_s;

   sync_fifo_param #(
      .width (8),
      .depth (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .n_rst        (n_rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en_s),
      .clr_overflow (clr_overflow),
      .rd_data      (rd_data_s),
      .full         (full),
      .empty        (empty_s),
      .count        (count),
      .overflow     (overflow)
   );

   assign empty   = empty_s;
   assign tx_data = tx_data_r;
   assign tx_send = tx_send_r;
   assign busy    = busy_r;

   // Drain FSM next-state; the FIFO pop is issued only from LOAD.
   always_comb begin
      state_nxt_s = state_r;
      rd_en_s     = 1'b0;
      case (state_r)
         TXF_IDLE: begin
            if (!empty_s) begin
               state_nxt_s = TXF_LOAD;
            end else begin
               state_nxt_s = TXF_IDLE;
            end
         end
         TXF_LOAD: begin
            rd_en_s     = 1'b1;
            state_nxt_s = TXF_SEND;
         end
         TXF_SEND: begin
            state_nxt_s = TXF_WAIT;
         end
         TXF_WAIT: begin
            if (cnt_r == CNT_ZERO) begin
               state_nxt_s = TXF_IDLE;
            end else begin
               state_nxt_s = TXF_WAIT;
            end
         end
         default: begin
            state_nxt_s = TXF_IDLE;
         end
      endcase
   end

   // State plus registered tx_send/busy, which track the state being entered so they align with it.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r   <= TXF_IDLE;
         tx_send_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         tx_send_r <= (state_nxt_s == TXF_SEND);
         busy_r    <= (state_nxt_s != TXF_IDLE);
      end
   end

   // Output byte is captured on the pop and held until the next frame is loaded.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         tx_data_r <= 8'h00;
      end else if (state_r == TXF_LOAD) begin
         tx_data_r <= rd_data_s;
      end else begin
         tx_data_r <= tx_data_r;
      end
   end

   // Frame-time counter: reloaded in SEND, counts down through WAIT.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_r <= CNT_ZERO;
      end else if (state_r == TXF_SEND) begin
         cnt_r <= CNT_LAST;
      end else if ((state_r == TXF_WAIT) && (cnt_r != CNT_ZERO)) begin
         cnt_r <= cnt_r - CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench for uart_tx_fifo; the reference model schedules each accepted
// byte's frame arithmetically and derives every output from that schedule.
module tb_uart_tx_fifo;

   localparam int DEPTH = 8;
   localparam int FRAME = 40;
   localparam int GAP   = 2;
   localparam int T     = FRAME + GAP;

   logic                   clk = 1'b0;
   logic                   n_rst = 1'b1;
   logic                   wr_en = 1'b0;
   logic [7:0]             wr_data = 8'h00;
   logic                   clr_overflow = 1'b0;
   logic [7:0]             tx_data;
   logic                   tx_send;
   logic                   full;
   logic                   empty;
   logic [$clog2(DEPTH):0] count;
   logic                   busy;
   logic                   overflow;

   uart_tx_fifo #(
      .DEPTH        (DEPTH),
      .FRAME_CYCLES (FRAME),
      .GAP_CYCLES   (GAP)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .clr_overflow (clr_overflow),
      .tx_data      (tx_data),
      .tx_send      (tx_send),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .busy         (busy),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   // One scheduled frame: tx_send visible after send_edge, block busy from send_edge-1 to busy_end.
   typedef struct {
      logic [7:0] data;
      int         send_edge;
      int         busy_end;
   } frame_t;

   frame_t     fq[$];
   int         edge_n = 0;
   int         idle_from = 0;
   logic [7:0] m_last = 8'h00;
   logic       m_ovf = 1'b0;
   int         obs_edge[$];
   logic [7:0] obs_data[$];
   int         chk_cnt = 0;
   int         err_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   function automatic int m_count(input int k);
      int n;
      n = 0;
      foreach (fq[i]) begin
         if (fq[i].send_edge > k) n++;
      end
      return n;
   endfunction

   task automatic compare_outputs();
      int   k;
      int   cnt;
      logic exp_send;
      logic exp_busy;
      k        = edge_n;
      exp_send = 1'b0;
      exp_busy = 1'b0;
      foreach (fq[i]) begin
         if (fq[i].send_edge == k) exp_send = 1'b1;
         if (fq[i].send_edge <= k) m_last = fq[i].data;
         if ((k >= fq[i].send_edge - 1) && (k <= fq[i].busy_end)) exp_busy = 1'b1;
      end
      while ((fq.size() > 0) && (fq[0].busy_end < k)) void'(fq.pop_front());
      cnt = m_count(k);
      if (tx_send === 1'b1) begin
         obs_edge.push_back(k);
         obs_data.push_back(tx_data);
      end
      check_val("tx_send", {31'd0, tx_send}, {31'd0, exp_send});
      check_val("tx_data", {24'd0, tx_data}, {24'd0, m_last});
      check_val("count", 32'(count), cnt);
      check_val("full", {31'd0, full}, {31'd0, (cnt == DEPTH)});
      check_val("empty", {31'd0, empty}, {31'd0, (cnt == 0)});
      check_val("busy", {31'd0, busy}, {31'd0, exp_busy});
      check_val("overflow", {31'd0, overflow}, {31'd0, m_ovf});
   endtask

   // One clock cycle: drive inputs, advance the model for the edge, compare on the falling edge.
   task automatic step(input logic we, input logic [7:0] d, input logic clr);
      int pre;
      int e;
      wr_en        = we;
      wr_data      = d;
      clr_overflow = clr;
      pre          = m_count(edge_n);
      @(posedge clk);
      edge_n++;
      if (we && (pre < DEPTH)) begin
         e = ((edge_n > idle_from) ? edge_n : idle_from) + 1;
         fq.push_back('{data: d, send_edge: e + 1, busy_end: e + 1 + T});
         idle_from = e + 2 + T;
      end
      if (we && (pre == DEPTH)) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      @(negedge clk);
      compare_outputs();
      wr_en        = 1'b0;
      clr_overflow = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   // Asynchronous reset between clock edges; outputs must drop before any edge arrives.
   task automatic do_reset();
      @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      check_val("rst_tx_send", {31'd0, tx_send}, 32'd0);
      check_val("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check_val("rst_count", 32'(count), 32'd0);
      check_val("rst_empty", {31'd0, empty}, 32'd1);
      check_val("rst_full", {31'd0, full}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_overflow", {31'd0, overflow}, 32'd0);
      fq.delete();
      m_last = 8'h00;
      m_ovf  = 1'b0;
      repeat (2) begin
         @(posedge clk);
         edge_n++;
      end
      @(negedge clk);
      n_rst     = 1'b1;
      idle_from = edge_n;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int idx;
      int budget;
      logic dropped_seen;

      // Reset, then sit idle.
      do_reset();
      obs_edge.delete();
      obs_data.delete();
      idle(100);
      check_val("t1_no_send", obs_edge.size(), 32'd0);

      // Single byte: pulse two edges after the accepting edge (i.e. in cycle N+3).
      step(1'b1, 8'h41, 1'b0);
      base   = edge_n;
      budget = 0;
      while ((obs_edge.size() == 0) && (budget < 20)) begin
         step(1'b0, 8'h00, 1'b0);
         budget++;
      end
      check_val("t2_seen", obs_edge.size(), 32'd1);
      if (obs_edge.size() > 0) begin
         check_val("t2_latency", obs_edge[0] - base, 32'd2);
         check_val("t2_data", {24'd0, obs_data[0]}, 32'h41);
      end
      idle(T + 5);
      check_val("t2_busy_done", {31'd0, busy}, 32'd0);
      check_val("t2_count_done", 32'(count), 32'd0);
      check_val("t2_one_pulse", obs_edge.size(), 32'd1);

      // Three back-to-back bytes, spaced by a full frame slot.
      obs_edge.delete();
      obs_data.delete();
      step(1'b1, 8'h48, 1'b0);
      step(1'b1, 8'h49, 1'b0);
      step(1'b1, 8'h0A, 1'b0);
      idle(3 * (T + 3) + 5);
      check_val("t3_pulses", obs_edge.size(), 32'd3);
      if (obs_edge.size() == 3) begin
         check_val("t3_d0", {24'd0, obs_data[0]}, 32'h48);
         check_val("t3_d1", {24'd0, obs_data[1]}, 32'h49);
         check_val("t3_d2", {24'd0, obs_data[2]}, 32'h0A);
         check_val("t3_gap01", obs_edge[1] - obs_edge[0], T + 3);
         check_val("t3_gap12", obs_edge[2] - obs_edge[1], T + 3);
      end

      // Fill while the first frame is in WAIT; the extra byte is dropped, set beats clear.
      obs_edge.delete();
      obs_data.delete();
      step(1'b1, 8'h55, 1'b0);
      idle(4);
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
      check_val("t4_full", {31'd0, full}, 32'd1);
      check_val("t4_no_ovf_yet", {31'd0, overflow}, 32'd0);
      step(1'b1, 8'hEE, 1'b1);
      check_val("t4_ovf_set_wins", {31'd0, overflow}, 32'd1);
      step(1'b0, 8'h00, 1'b1);
      check_val("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
      idle((DEPTH + 1) * (T + 3) + 5);
      check_val("t4_sent", obs_edge.size(), DEPTH + 1);
      dropped_seen = 1'b0;
      foreach (obs_data[i]) if (obs_data[i] == 8'hEE) dropped_seen = 1'b1;
      check_val("t4_dropped_unsent", {31'd0, dropped_seen}, 32'd0);

      // Pointer wrap: 3*DEPTH bytes with randomly paced pushes that never hit full.
      obs_edge.delete();
      obs_data.delete();
      idx = 0;
      while (idx < 3 * DEPTH) begin
         if ((m_count(edge_n) < DEPTH - 1) && ($urandom_range(0, 3) != 0)) begin
            step(1'b1, 8'(idx), 1'b0);
            idx++;
         end else begin
            step(1'b0, 8'h00, 1'b0);
         end
      end
      idle((DEPTH + 1) * (T + 3));
      check_val("t5_sent", obs_edge.size(), 3 * DEPTH);
      foreach (obs_data[i]) check_val("t5_order", {24'd0, obs_data[i]}, 32'(i));
      check_val("t5_no_ovf", {31'd0, overflow}, 32'd0);

      // Reset during WAIT with five bytes queued.
      step(1'b1, 8'hA0, 1'b0);
      idle(4);
      for (int i = 1; i <= 5; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
      check_val("t6_count5", 32'(count), 32'd5);
      check_val("t6_busy", {31'd0, busy}, 32'd1);
      do_reset();
      obs_edge.delete();
      obs_data.delete();
      idle(T + 10);
      check_val("t6_quiet", obs_edge.size(), 32'd0);

      // Random traffic including overflow and clear pulses.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 15) == 0));
      end
      idle((DEPTH + 1) * (T + 3));

      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end

endmodule
